// File: rtl/tlb_miss_replay_queue.sv
// Holding queue for AGU uops that missed the TLB; replays them once translated.
// Define TLBMQ_AGE_ORDER_EN to issue the oldest eligible entry instead of the highest index.
package tlb_miss_replay_queue_pkg;
    localparam int unsigned SQN_W    = 8;
    localparam int unsigned PW_VPN_W = 20;

    typedef struct packed {
        logic             taken;
        logic [SQN_W-1:0] sqN;
    } BranchProv;

    typedef struct packed {
        logic sv32en;
    } VirtMemState;

    typedef struct packed {
        logic                valid;
        logic                isSuperPage;
        logic [PW_VPN_W-1:0] vpn;
    } PageWalk_Res;

    typedef struct packed {
        logic             valid;
        logic [31:0]      addr;
        logic [SQN_W-1:0] sqN;
        logic             isStore;
        logic [1:0]       size;
    } AGU_UOp;
endpackage

module tlb_miss_replay_queue
    import tlb_miss_replay_queue_pkg::*;
#(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned VPN_W = 20,
    parameter int unsigned SPN_W = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [$clog2(SIZE+1)-1:0] OUT_free,
    output logic                      OUT_ready,
    input  BranchProv                 IN_branch,
    input  VirtMemState               IN_vmem,
    input  PageWalk_Res               IN_pw,
    input  logic                      IN_pwActive,
    input  logic                      IN_sfence,
    input  logic                      IN_enqueue,
    input  logic                      IN_uopReady,
    input  AGU_UOp                    IN_uop,
    input  logic                      IN_dequeue,
    output AGU_UOp                    OUT_uop
);
    localparam int unsigned IDX_W  = $clog2(SIZE);
    localparam int unsigned FREE_W = $clog2(SIZE + 1);

    logic [SIZE-1:0] ent_valid;
    logic [SIZE-1:0] ent_ready;
    AGU_UOp          ent_uop [SIZE];
    AGU_UOp          out_uop_q;

    logic [FREE_W-1:0] free_cnt;
    logic [IDX_W-1:0]  idx_in;
    logic [IDX_W-1:0]  idx_sel;
    logic              any_free;
    logic              any_elig;
    logic              enq_fire;
    logic              enq_ready;
    logic              issue;
    logic              out_kill;
    logic [SIZE-1:0]   ent_kill;
    logic [SIZE-1:0]   ent_wake;
    logic [SIZE-1:0]   eligible;

    // Wrap-safe: sqn is younger than the branch when (sqn - branch) is positive.
    function automatic logic br_kills(input BranchProv br, input logic [SQN_W-1:0] sqn);
        logic [SQN_W-1:0] d;
        d = sqn - br.sqN;
        return br.taken && !d[SQN_W-1] && (d != '0);
    endfunction

    function automatic logic is_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] d;
        d = a - b;
        return d[SQN_W-1];
    endfunction

    function automatic logic pw_match(input PageWalk_Res pw, input logic [31:0] addr);
        logic m;
        if (pw.isSuperPage)
            m = (pw.vpn[VPN_W-1 -: SPN_W] == addr[31 -: SPN_W]);
        else
            m = (pw.vpn[VPN_W-1:0] == addr[31 -: VPN_W]);
        return m;
    endfunction

    always_comb begin
        free_cnt = '0;
        idx_in   = '0;
        any_free = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (!ent_valid[i]) begin
                free_cnt = free_cnt + FREE_W'(1);
                if (!any_free) begin
                    idx_in   = IDX_W'(i);
                    any_free = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ent_kill = '0;
        ent_wake = '0;
        eligible = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            ent_kill[i] = br_kills(IN_branch, ent_uop[i].sqN);
            ent_wake[i] = IN_pw.valid && !IN_sfence && pw_match(IN_pw, ent_uop[i].addr);
            eligible[i] = ent_valid[i] && (ent_ready[i] || !IN_pwActive) && !ent_kill[i];
        end
    end

    always_comb begin
        idx_sel  = '0;
        any_elig = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
`ifdef TLBMQ_AGE_ORDER_EN
            if (eligible[i] && (!any_elig || is_older(ent_uop[i].sqN, ent_uop[idx_sel].sqN))) begin
`else
            if (eligible[i]) begin
`endif
                idx_sel  = IDX_W'(i);
                any_elig = 1'b1;
            end
        end
    end

    assign enq_fire  = IN_enqueue && IN_uop.valid && !br_kills(IN_branch, IN_uop.sqN) && any_free;
    assign enq_ready = !IN_sfence &&
                       (!IN_vmem.sv32en || IN_uopReady || (IN_pw.valid && pw_match(IN_pw, IN_uop.addr)));
    assign issue     = (!out_uop_q.valid || IN_dequeue) && any_elig;
    assign out_kill  = br_kills(IN_branch, out_uop_q.sqN);

    // Pessimistic: a held OUT_uop may still need a slot if it gets replayed again.
    assign OUT_free  = free_cnt - FREE_W'(out_uop_q.valid && (free_cnt != '0));
    assign OUT_ready = any_free;
    assign OUT_uop   = out_uop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid <= '0;
            ent_ready <= '0;
            out_uop_q <= '0;
        end else begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (enq_fire && (idx_in == IDX_W'(i))) begin
                    ent_valid[i] <= 1'b1;
                    ent_ready[i] <= enq_ready;
                end else if (ent_valid[i]) begin
                    if (ent_kill[i] || (issue && (idx_sel == IDX_W'(i)))) begin
                        ent_valid[i] <= 1'b0;
                        ent_ready[i] <= 1'b0;
                    end else if (IN_sfence) begin
                        ent_ready[i] <= 1'b0;
                    end else if (ent_wake[i]) begin
                        ent_ready[i] <= 1'b1;
                    end
                end
            end

            if (issue) begin
                out_uop_q       <= ent_uop[idx_sel];
                out_uop_q.valid <= 1'b1;
            end else if (IN_dequeue || out_kill) begin
                out_uop_q.valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire)
            ent_uop[idx_in] <= IN_uop;
    end

    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(IN_enqueue && IN_uop.valid && !any_free));

endmodule

// File: tb/tb_tlb_miss_replay_queue.sv
// Scoreboard bench for tlb_miss_replay_queue (default selection: highest-index eligible).
module tb_tlb_miss_replay_queue;
    import tlb_miss_replay_queue_pkg::*;

    localparam int unsigned SIZE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  OUT_free;
    logic        OUT_ready;
    BranchProv   IN_branch;
    VirtMemState IN_vmem;
    PageWalk_Res IN_pw;
    logic        IN_pwActive;
    logic        IN_sfence;
    logic        IN_enqueue;
    logic        IN_uopReady;
    AGU_UOp      IN_uop;
    logic        IN_dequeue;
    AGU_UOp      OUT_uop;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    AGU_UOp      exp_q[$];
    AGU_UOp      exp_u;

    tlb_miss_replay_queue #(.SIZE(SIZE), .VPN_W(20), .SPN_W(10)) dut (
        .clk(clk), .rst(rst), .OUT_free(OUT_free), .OUT_ready(OUT_ready),
        .IN_branch(IN_branch), .IN_vmem(IN_vmem), .IN_pw(IN_pw), .IN_pwActive(IN_pwActive),
        .IN_sfence(IN_sfence), .IN_enqueue(IN_enqueue), .IN_uopReady(IN_uopReady),
        .IN_uop(IN_uop), .IN_dequeue(IN_dequeue), .OUT_uop(OUT_uop)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IN_branch   = '0;
        IN_vmem     = '0;
        IN_pw       = '0;
        IN_pwActive = 1'b0;
        IN_sfence   = 1'b0;
        IN_enqueue  = 1'b0;
        IN_uopReady = 1'b0;
        IN_uop      = '0;
        IN_dequeue  = 1'b0;
    endtask

    function automatic AGU_UOp mk_uop(input logic [31:0] addr, input logic [7:0] sqn);
        AGU_UOp u;
        u.valid   = 1'b1;
        u.addr    = addr;
        u.sqN     = sqn;
        u.isStore = sqn[0];
        u.size    = 2'b10;
        return u;
    endfunction

    function automatic AGU_UOp sb_pop();
        AGU_UOp u = '0;
        if (exp_q.size() != 0) u = exp_q.pop_front();
        return u;
    endfunction

    function automatic PageWalk_Res mk_pw(input logic sp, input logic [19:0] vpn);
        PageWalk_Res p;
        p.valid       = 1'b1;
        p.isSuperPage = sp;
        p.vpn         = vpn;
        return p;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        idle();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        n_checks++; if (OUT_free !== 3'd4) $display("FAIL reset_free: got %0d expected 4", OUT_free); else n_pass++;
        n_checks++; if (OUT_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", OUT_ready); else n_pass++;
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", OUT_uop.valid); else n_pass++;
    endtask

    task automatic test_pw_wakeup();
        IN_vmem.sv32en = 1'b1;
        IN_pwActive    = 1'b1;
        IN_enqueue     = 1'b1;
        IN_uop         = mk_uop(32'h1234_5000, 8'd1);
        exp_q.push_back(IN_uop);
        tick();
        IN_enqueue = 1'b0;
        IN_uop     = '0;
        repeat (3) tick();
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL pw_blocked: got valid %b expected 0", OUT_uop.valid); else n_pass++;
        IN_pw = mk_pw(1'b0, 20'h12345);
        tick();
        IN_pw = '0;
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL pw_latency: got valid %b expected 0", OUT_uop.valid); else n_pass++;
        tick();
        exp_u = sb_pop();
        n_checks++; if (OUT_uop !== exp_u) $display("FAIL pw_issue: got %h expected %h", OUT_uop, exp_u); else n_pass++;
        IN_dequeue = 1'b1;
        tick();
        IN_dequeue = 1'b0;
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL pw_dequeue: got valid %b expected 0", OUT_uop.valid); else n_pass++;
        idle();
    endtask

    task automatic test_sfence();
        IN_vmem.sv32en = 1'b1;
        IN_pwActive    = 1'b1;
        IN_enqueue     = 1'b1;
        IN_uopReady    = 1'b1;
        IN_sfence      = 1'b1;
        IN_uop         = mk_uop(32'h0ABC_D000, 8'd50);
        exp_q.push_back(IN_uop);
        tick();
        IN_enqueue  = 1'b0;
        IN_uopReady = 1'b0;
        IN_uop      = '0;
        IN_pw       = mk_pw(1'b0, 20'h0ABCD);
        tick();
        IN_sfence = 1'b0;
        IN_pw     = '0;
        tick();
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL sfence_suppress: got valid %b expected 0", OUT_uop.valid); else n_pass++;
        IN_pw = mk_pw(1'b0, 20'h0ABCD);
        tick();
        IN_pw = '0;
        tick();
        exp_u = sb_pop();
        n_checks++; if (OUT_uop !== exp_u) $display("FAIL sfence_rewake: got %h expected %h", OUT_uop, exp_u); else n_pass++;
        IN_dequeue = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_superpage();
        AGU_UOp ua, ub, uc;
        ua = mk_uop(32'h1200_0000, 8'd2);
        ub = mk_uop(32'h123F_F000, 8'd3);
        uc = mk_uop(32'h1240_0000, 8'd4);
        IN_vmem.sv32en = 1'b1;
        IN_pwActive    = 1'b1;
        IN_enqueue     = 1'b1;
        IN_uop = ua; tick();
        IN_uop = ub; tick();
        IN_uop = uc; tick();
        IN_enqueue = 1'b0;
        IN_uop     = '0;
        // vpn[19:10]=0x048 wakes A (idx0) and B (idx1); B issues first by index priority
        IN_pw = mk_pw(1'b1, 20'h12000);
        exp_q.push_back(ub);
        exp_q.push_back(ua);
        tick();
        IN_pw      = '0;
        IN_dequeue = 1'b1;
        tick();
        exp_u = sb_pop();
        n_checks++; if (OUT_uop !== exp_u) $display("FAIL super_first: got %h expected %h", OUT_uop, exp_u); else n_pass++;
        tick();
        exp_u = sb_pop();
        n_checks++; if (OUT_uop !== exp_u) $display("FAIL super_second: got %h expected %h", OUT_uop, exp_u); else n_pass++;
        tick();
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL super_no_wake: got valid %b expected 0", OUT_uop.valid); else n_pass++;
        n_checks++; if (OUT_free !== 3'd3) $display("FAIL super_free: got %0d expected 3", OUT_free); else n_pass++;
        IN_pwActive = 1'b0;
        exp_q.push_back(uc);
        tick();
        exp_u = sb_pop();
        n_checks++; if (OUT_uop !== exp_u) $display("FAIL super_walk_retry: got %h expected %h", OUT_uop, exp_u); else n_pass++;
        tick();
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL super_drain: got valid %b expected 0", OUT_uop.valid); else n_pass++;
        idle();
    endtask

    task automatic test_fill();
        logic [2:0] exp_free [4];
        exp_free = '{3'd0, 3'd1, 3'd2, 3'd3};
        // sq20 goes straight to OUT_uop; entries end as idx0=22 idx1=21 idx2=23 idx3=24
        exp_q.push_back(mk_uop(32'h4000_0000, 8'd20));
        exp_q.push_back(mk_uop(32'h4000_4000, 8'd24));
        exp_q.push_back(mk_uop(32'h4000_3000, 8'd23));
        exp_q.push_back(mk_uop(32'h4000_1000, 8'd21));
        exp_q.push_back(mk_uop(32'h4000_2000, 8'd22));
        IN_enqueue = 1'b1;
        for (int k = 0; k < 5; k++) begin
            IN_uop = mk_uop(32'h4000_0000 + (k << 12), 8'(20 + k));
            tick();
        end
        IN_enqueue = 1'b0;
        IN_uop     = '0;
        n_checks++; if (OUT_free !== 3'd0) $display("FAIL fill_free: got %0d expected 0", OUT_free); else n_pass++;
        n_checks++; if (OUT_ready !== 1'b0) $display("FAIL fill_ready: got %b expected 0", OUT_ready); else n_pass++;
        exp_u = sb_pop();
        n_checks++; if (OUT_uop !== exp_u) $display("FAIL fill_out: got %h expected %h", OUT_uop, exp_u); else n_pass++;
        IN_dequeue = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            exp_u = sb_pop();
            n_checks++; if (OUT_uop !== exp_u) $display("FAIL drain_order[%0d]: got %h expected %h", j, OUT_uop, exp_u); else n_pass++;
            n_checks++; if (OUT_free !== exp_free[j]) $display("FAIL drain_free[%0d]: got %0d expected %0d", j, OUT_free, exp_free[j]); else n_pass++;
        end
        tick();
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL drain_empty: got valid %b expected 0", OUT_uop.valid); else n_pass++;
        n_checks++; if (OUT_free !== 3'd4) $display("FAIL drain_free_end: got %0d expected 4", OUT_free); else n_pass++;
        idle();
    endtask

    task automatic test_branch();
        IN_vmem.sv32en = 1'b1;
        IN_pwActive    = 1'b1;
        IN_enqueue     = 1'b1;
        IN_uopReady    = 1'b1;
        IN_uop         = mk_uop(32'h5000_D000, 8'd13);
        exp_q.push_back(IN_uop);
        tick();
        IN_uopReady = 1'b0;
        IN_uop      = mk_uop(32'h5000_8000, 8'd8);
        tick();
        exp_u = sb_pop();
        n_checks++; if (OUT_uop !== exp_u) $display("FAIL branch_setup_out: got %h expected %h", OUT_uop, exp_u); else n_pass++;
        IN_uop = mk_uop(32'h5000_B000, 8'd11); tick();
        IN_uop = mk_uop(32'h5000_C000, 8'd12); tick();
        n_checks++; if (OUT_free !== 3'd0) $display("FAIL branch_pre_free: got %0d expected 0", OUT_free); else n_pass++;
        IN_branch.taken = 1'b1;
        IN_branch.sqN   = 8'd10;
        IN_uop          = mk_uop(32'h5000_F000, 8'd15);
        tick();
        IN_branch  = '0;
        IN_enqueue = 1'b0;
        IN_uop     = '0;
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL branch_kill_out: got valid %b expected 0", OUT_uop.valid); else n_pass++;
        n_checks++; if (OUT_free !== 3'd3) $display("FAIL branch_free: got %0d expected 3", OUT_free); else n_pass++;
        IN_pwActive = 1'b0;
        exp_q.push_back(mk_uop(32'h5000_8000, 8'd8));
        tick();
        exp_u = sb_pop();
        n_checks++; if (OUT_uop !== exp_u) $display("FAIL branch_survivor: got %h expected %h", OUT_uop, exp_u); else n_pass++;
        IN_dequeue = 1'b1;
        tick();
        n_checks++; if (OUT_free !== 3'd4) $display("FAIL branch_drain_free: got %0d expected 4", OUT_free); else n_pass++;
        idle();
    endtask

    task automatic test_branch_wrap();
        IN_vmem.sv32en = 1'b1;
        IN_pwActive    = 1'b1;
        IN_enqueue     = 1'b1;
        IN_uop = mk_uop(32'h7000_0000, 8'hFD); tick();
        IN_uop = mk_uop(32'h7000_1000, 8'h01); tick();
        IN_enqueue      = 1'b0;
        IN_uop          = '0;
        IN_branch.taken = 1'b1;
        IN_branch.sqN   = 8'hFE;
        tick();
        IN_branch = '0;
        n_checks++; if (OUT_free !== 3'd3) $display("FAIL wrap_kill_free: got %0d expected 3", OUT_free); else n_pass++;
        IN_pwActive = 1'b0;
        exp_q.push_back(mk_uop(32'h7000_0000, 8'hFD));
        tick();
        exp_u = sb_pop();
        n_checks++; if (OUT_uop !== exp_u) $display("FAIL wrap_survivor: got %h expected %h", OUT_uop, exp_u); else n_pass++;
        IN_dequeue = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        IN_dequeue = 1'b1;
        IN_enqueue = 1'b1;
        for (int k = 0; k < 6; k++) begin
            IN_uop = mk_uop(32'h6000_0000 + (k << 12), 8'(30 + k));
            exp_q.push_back(IN_uop);
            tick();
            if (k == 0) begin
                n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL b2b_latency: got valid %b expected 0", OUT_uop.valid); else n_pass++;
            end else begin
                exp_u = sb_pop();
                n_checks++; if (OUT_uop !== exp_u) $display("FAIL b2b_issue[%0d]: got %h expected %h", k, OUT_uop, exp_u); else n_pass++;
            end
        end
        IN_enqueue = 1'b0;
        IN_uop     = '0;
        tick();
        exp_u = sb_pop();
        n_checks++; if (OUT_uop !== exp_u) $display("FAIL b2b_last: got %h expected %h", OUT_uop, exp_u); else n_pass++;
        tick();
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL b2b_empty: got valid %b expected 0", OUT_uop.valid); else n_pass++;
        idle();
    endtask

    task automatic test_reset_midrun();
        IN_vmem.sv32en = 1'b1;
        IN_pwActive    = 1'b1;
        IN_enqueue     = 1'b1;
        IN_uopReady    = 1'b1;
        IN_uop         = mk_uop(32'h8000_0000, 8'd40); tick();
        IN_uopReady    = 1'b0;
        IN_uop         = mk_uop(32'h8000_1000, 8'd41); tick();
        IN_uop         = mk_uop(32'h8000_2000, 8'd42); tick();
        IN_uop         = mk_uop(32'h8000_3000, 8'd43); tick();
        IN_enqueue = 1'b0;
        IN_uop     = '0;
        n_checks++; if (OUT_uop.valid !== 1'b1) $display("FAIL midrun_out_valid: got %b expected 1", OUT_uop.valid); else n_pass++;
        n_checks++; if (OUT_free !== 3'd0) $display("FAIL midrun_free: got %0d expected 0", OUT_free); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL async_reset_out: got %b expected 0", OUT_uop.valid); else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (OUT_free !== 3'd4) $display("FAIL midrun_reset_free: got %0d expected 4", OUT_free); else n_pass++;
        n_checks++; if (OUT_ready !== 1'b1) $display("FAIL midrun_reset_ready: got %b expected 1", OUT_ready); else n_pass++;
        n_checks++; if (OUT_uop.valid !== 1'b0) $display("FAIL midrun_reset_out: got %b expected 0", OUT_uop.valid); else n_pass++;
        exp_q.delete();
        idle();
    endtask

    initial begin
        test_reset();
        test_pw_wakeup();
        test_sfence();
        test_superpage();
        test_fill();
        test_branch();
        test_branch_wrap();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
